program_loader: RTL and testbench

Writes a program image into the core's program memory from an 8-bit byte stream, then releases the core to run it. Sits between a host byte source (UART receiver or testbench) and the program-memory write port. Holds the control unit in reset until a complete, valid image has been written.

---
 rtl/program_loader.sv | 163 ++++++++++++++++
 tb/tb_program_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
//   Streams a big-endian program image (LEN_HI, LEN_LO, then N words as
//   HI/LO bytes) from a byte source into program memory, holding the core in
//   reset until a complete image has been written.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, two checksum bytes (CHK_HI, CHK_LO) follow the data and
//     must equal the XOR of all written words, otherwise the load is rejected.
//
// Ports
//   clock, reset       rising-edge clock, synchronous active-high reset
//   load_start         one-cycle pulse: start or restart a load
//   rx_data/rx_valid   incoming byte; accepted when rx_valid && rx_ready
//   rx_ready           a byte can be accepted this cycle
//   pm_write/addr/data program-memory write port (one-cycle strobe)
//   core_reset         high holds the core; low only once the image is done
//   done / error       load finished successfully / load rejected
//   words_loaded       words written in the current load
module program_loader #(
  parameter int PC_WIDTH = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_start,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                pm_write,
  output logic [PC_WIDTH-1:0] pm_addr,
  output logic [15:0]         pm_data,
  output logic                core_reset,
  output logic                done,
  output logic                error,
  output logic [PC_WIDTH-1:0] words_loaded
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LEN_HI  = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_WRITE   = 4'd5;
  localparam logic [3:0] S_CHK_HI  = 4'd6;
  localparam logic [3:0] S_CHK_LO  = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;
  localparam logic [3:0] S_ERROR   = 4'd9;

  // The top address is the core's halt address, so one fewer word fits.
  localparam logic [15:0] MAX_WORDS = 16'((1 << PC_WIDTH) - 1);

`ifdef LOADER_CHECKSUM_EN
  localparam logic [3:0] S_AFTER_DATA = S_CHK_HI;
`else
  localparam logic [3:0] S_AFTER_DATA = S_DONE;
`endif

  logic [3:0]          state, state_nxt;
  logic [7:0]          len_hi;
  logic [7:0]          hi_byte;
  logic [PC_WIDTH-1:0] word_count;
  logic [15:0]         len_word;
  logic                accept;
  logic                last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]         csum;
  logic [7:0]          chk_hi;
`endif

  assign accept    = rx_valid && rx_ready;
  assign len_word  = {len_hi, rx_data};
  assign last_word = (words_loaded == word_count - PC_WIDTH'(1));

  always_comb begin
    state_nxt = state;
    if (load_start) begin
      // Restart wins over any byte presented in the same cycle.
      state_nxt = S_LEN_HI;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_IDLE;
        S_LEN_HI:  if (accept) state_nxt = S_LEN_LO;
        S_LEN_LO:
          if (accept) begin
            if (len_word == 16'd0)          state_nxt = S_AFTER_DATA;
            else if (len_word > MAX_WORDS)  state_nxt = S_ERROR;
            else                            state_nxt = S_DATA_HI;
          end
        S_DATA_HI: if (accept) state_nxt = S_DATA_LO;
        S_DATA_LO: if (accept) state_nxt = S_WRITE;
        S_WRITE:   state_nxt = last_word ? S_AFTER_DATA : S_DATA_HI;
`ifdef LOADER_CHECKSUM_EN
        S_CHK_HI:  if (accept) state_nxt = S_CHK_LO;
        S_CHK_LO:
          if (accept) state_nxt = ({chk_hi, rx_data} == csum) ? S_DONE : S_ERROR;
`endif
        S_DONE:    state_nxt = S_DONE;
        S_ERROR:   state_nxt = S_ERROR;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      rx_ready     <= 1'b0;
      pm_write     <= 1'b0;
      pm_addr      <= '0;
      pm_data      <= '0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len_hi       <= '0;
      hi_byte      <= '0;
      word_count   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
      chk_hi       <= '0;
`endif
    end else begin
      state <= state_nxt;
      // Status outputs are registered from the next state so they line up
      // with the state they describe.
      rx_ready   <= (state_nxt == S_LEN_HI)  || (state_nxt == S_LEN_LO) ||
                    (state_nxt == S_DATA_HI) || (state_nxt == S_DATA_LO) ||
                    (state_nxt == S_CHK_HI)  || (state_nxt == S_CHK_LO);
      pm_write   <= (state_nxt == S_WRITE);
      core_reset <= (state_nxt != S_DONE);
      done       <= (state_nxt == S_DONE);
      error      <= (state_nxt == S_ERROR);

      if (load_start) begin
        words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end else begin
        case (state)
          S_LEN_HI:  if (accept) len_hi <= rx_data;
          S_LEN_LO:  if (accept) word_count <= len_word[PC_WIDTH-1:0];
          S_DATA_HI: if (accept) hi_byte <= rx_data;
          S_DATA_LO:
            if (accept) begin
              pm_data <= {hi_byte, rx_data};
              pm_addr <= words_loaded;
            end
          S_WRITE: begin
            words_loaded <= words_loaded + PC_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
            csum         <= csum ^ pm_data;
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          S_CHK_HI:  if (accept) chk_hi <= rx_data;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader (PC_WIDTH=6). The stimulus side builds
// each image, pushes the expected writes and the expected outcome into
// queues, then streams the bytes; an independent monitor pops and compares
// on every pm_write and on every rising edge of done/error.
module tb_program_loader;
  localparam int PCW = 6;
  localparam int MAXW = (1 << PCW) - 1;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           load_start = 1'b0;
  logic [7:0]     rx_data = '0;
  logic           rx_valid = 1'b0;
  logic           rx_ready, pm_write, core_reset, done, error;
  logic [PCW-1:0] pm_addr, words_loaded;
  logic [15:0]    pm_data;

  program_loader #(.PC_WIDTH(PCW)) dut (
    .clock(clock), .reset(reset), .load_start(load_start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .pm_write(pm_write), .pm_addr(pm_addr), .pm_data(pm_data),
    .core_reset(core_reset), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  typedef struct { int addr; logic [15:0] data; } wr_t;
  // ok: done expected (else error); delta: cycles from last accepted byte's
  // edge to the edge where done/error first appears.
  typedef struct { bit ok; int words; int delta; } end_t;

  wr_t         wr_q[$];
  end_t        end_q[$];
  logic [15:0] fixed_words[$];
  int tests = 0, fails = 0;
  int cyc = 0, last_acc = 0;
  bit end_prev = 0;

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock)
    if (!reset && rx_valid && rx_ready && !load_start) last_acc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (pm_write) begin
        if (wr_q.size() == 0) check("unexpected_write_addr", int'(pm_addr), -1);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check("write_addr", int'(pm_addr), w.addr);
          check("write_data", int'(pm_data), int'(w.data));
        end
      end
      if ((done || error) && !end_prev) begin
        if (end_q.size() == 0) check("unexpected_end", int'({done, error}), 0);
        else begin
          end_t e;
          e = end_q.pop_front();
          check("end_done", int'(done), int'(e.ok));
          check("end_error", int'(error), int'(!e.ok));
          check("end_core_reset", int'(core_reset), int'(!e.ok));
          check("end_words", int'(words_loaded), e.words);
          check("end_latency", cyc - last_acc, e.delta);
        end
      end
      end_prev = done || error;
    end
  end

  task automatic send(input logic [7:0] b, input int mode);
    int st, g;
    st = (mode == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 4)) : 0;
    rx_valid = 1'b0;
    repeat (st) begin rx_data = 8'($urandom); @(negedge clock); end
    rx_valid = 1'b1;
    rx_data  = b;
    g = 0;
    while (!rx_ready && g < 100) begin @(negedge clock); g++; end
    if (!rx_ready) check("send_timeout", 0, 1);
    @(negedge clock);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
    check("start_done", int'(done), 0);
    check("start_error", int'(error), 0);
    check("start_words", int'(words_loaded), 0);
    check("start_rx_ready", int'(rx_ready), 1);
  endtask

  task automatic wait_q();
    int g;
    g = 0;
    while ((wr_q.size() != 0 || end_q.size() != 0) && g < 2000) begin
      @(negedge clock); g++;
    end
    if (wr_q.size() != 0 || end_q.size() != 0) check("drain_timeout", wr_q.size() + end_q.size(), 0);
    wr_q.delete();
    end_q.delete();
  endtask

  // Reference: N words at addresses 0..N-1; N above MAXW is rejected right
  // after the length; checksum (when built) is the XOR of the words.
  task automatic load_image(input logic [15:0] n, input bit bad, input int mode);
    logic [15:0] words[$];
    logic [15:0] x, chk;
    end_t e;
    x = '0;
    if (int'(n) > MAXW) e = '{0, 0, 0};
    else begin
      for (int i = 0; i < int'(n); i++) begin
        logic [15:0] w;
        w = (fixed_words.size() != 0) ? fixed_words.pop_front() : 16'($urandom);
        words.push_back(w);
        wr_q.push_back('{i, w});
        x ^= w;
      end
`ifdef LOADER_CHECKSUM_EN
      e = '{!bad, int'(n), 0};
`else
      e = '{1, int'(n), (n == 0) ? 0 : 1};
`endif
    end
    fixed_words.delete();
    end_q.push_back(e);
    pulse_start();
    send(n[15:8], mode);
    send(n[7:0], mode);
    if (int'(n) <= MAXW) begin
      foreach (words[i]) begin send(words[i][15:8], mode); send(words[i][7:0], mode); end
`ifdef LOADER_CHECKSUM_EN
      chk = bad ? (x ^ 16'h0001) : x;
      send(chk[15:8], mode);
      send(chk[7:0], mode);
`else
      chk = x;
      if (bad && chk == 16'hFFFF) check("no_chk_build_bad_flag", 0, 1);
`endif
    end
    wait_q();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, int'(rx_ready), 0);
    check({tag, "_pm_write"}, int'(pm_write), 0);
    check({tag, "_pm_addr"}, int'(pm_addr), 0);
    check({tag, "_pm_data"}, int'(pm_data), 0);
    check({tag, "_core_reset"}, int'(core_reset), 1);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_error"}, int'(error), 0);
    check({tag, "_words"}, int'(words_loaded), 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check_reset_vals("reset");

    // Directed two-word image
    fixed_words.push_back(16'h1234);
    fixed_words.push_back(16'hABCD);
    load_image(16'd2, 0, 0);

    // Largest image, then oversize length
    load_image(16'd63, 0, 0);
    load_image(16'd64, 0, 0);
    load_image(16'd0, 0, 0);

`ifdef LOADER_CHECKSUM_EN
    fixed_words.push_back(16'h1234);
    load_image(16'd1, 1, 0);
    load_image(16'd3, 0, 0);
`endif

    // Restart mid-load after three data bytes of a 4-word image
    wr_q.push_back('{0, 16'h1234});
    pulse_start();
    send(8'h00, 0); send(8'h04, 0);
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0);
    wait_q();
    fixed_words.push_back(16'hBEEF);
    load_image(16'd1, 0, 0);

    // Same image contiguous and with 1-of-3 valid pattern
    for (int m = 0; m < 2; m++) begin
      fixed_words.push_back(16'h0F0F);
      fixed_words.push_back(16'hA5A5);
      fixed_words.push_back(16'h8001);
      load_image(16'd3, 0, m);
    end

    // Randomized images
    for (int k = 0; k < 16; k++) begin
      int r;
      logic [15:0] n;
      r = int'($urandom_range(0, 9));
      n = (r == 0) ? 16'($urandom_range(64, 65535)) :
          (r == 1) ? 16'd0 : 16'($urandom_range(1, 20));
      load_image(n, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
    end

    // Reset mid-load
    wr_q.push_back('{0, 16'hC0DE});
    pulse_start();
    send(8'h00, 0); send(8'h05, 0);
    send(8'hC0, 0); send(8'hDE, 0); send(8'h11, 0);
    wait_q();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals("midreset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
